// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared encodings, widths and FSM state type for the calc port responder
package calc_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/calc_port_responder_if.sv
// rtl/calc_port_responder_if.sv - command/response port bundle for the calc port responder
interface calc_port_responder_if;
    import calc_pkg::*;

    logic [3:0]        req_cmd_in;
    logic [DATA_W-1:0] req_data_in;
    logic [1:0]        out_resp;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    modport slave (
        input  req_cmd_in,
        input  req_data_in,
        output out_resp,
        output out_data,
        output busy
    );

    modport master (
        output req_cmd_in,
        output req_data_in,
        input  out_resp,
        input  out_data,
        input  busy
    );

endinterface

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - combinational add/sub/shift unit with error flag
module calc_alu
    import calc_pkg::*;
(
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, op1} + {1'b0, op2};

    // Select the operation; any error forces the result to zero.
    always_comb begin
        result = '0;
        err    = 1'b0;
        unique case (cmd)
            CMD_ADD: begin
                if (sum[DATA_W]) err = 1'b1;
                else             result = sum[DATA_W-1:0];
            end
            CMD_SUB: begin
                if (op2 > op1) err = 1'b1;
                else           result = op1 - op2;
            end
            CMD_SHL: result = op1 << op2[4:0];
            CMD_SHR: result = op1 >> op2[4:0];
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/calc_port_responder.sv
// rtl/calc_port_responder.sv - two-beat command port with fixed-latency registered response
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic                  c_clk,
    input  logic                  reset,
    calc_port_responder_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        resp_q, resp_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_err;

    // The ALU only ever sees latched operands, so late input changes cannot leak in.
    calc_alu u_alu (
        .cmd    (cmd_q),
        .op1    (op1_q),
        .op2    (op2_q),
        .result (alu_result),
        .err    (alu_err)
    );

    // Next-state, operand capture, latency countdown and response generation.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        resp_d  = RESP_NONE;
        data_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_cmd_in != CMD_NOP) begin
                    cmd_d   = bus.req_cmd_in;
                    op1_d   = bus.req_data_in;
                    state_d = ST_OP2;
                end
            end
            ST_OP2: begin
                op2_d   = bus.req_data_in;
                cnt_d   = CNT_LOAD;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    resp_d  = alu_err ? RESP_ERR : RESP_OK;
                    data_d  = alu_err ? '0 : alu_result;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset clears everything and drops any pending work.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= RESP_NONE;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.out_resp = resp_q;
    assign bus.out_data = data_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// tb/tb_calc_port_responder.sv - scoreboard bench for calc_port_responder
module tb_calc_port_responder;
    import calc_pkg::*;

    localparam int LAT = 3;

    logic c_clk = 1'b0;
    logic reset;
    int   cyc = 0;

    calc_port_responder_if bus ();

    calc_port_responder #(.LATENCY(LAT)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 c_clk = ~c_clk;

    always @(posedge c_clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every visible response must match the oldest expectation, at its cycle.
    always @(negedge c_clk) begin
        if (bus.out_resp !== RESP_NONE) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got resp %0d data %h at cycle %0d, want none",
                         bus.out_resp, bus.out_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("resp", 32'(bus.out_resp), 32'(mon_e.resp));
                check("data", bus.out_data, mon_e.data);
                check("resp_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end else begin
            check("idle_data", bus.out_data, 32'h0);
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 4 * LAT + 10 && bus.busy; i++) @(negedge c_clk);
        check("idle_timeout", 32'(bus.busy), 32'h0);
    endtask

    // Called at a negedge: presents cmd+op1, then op2, then junk; optionally keeps
    // firing commands while busy, which must all be ignored.
    task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] er, input logic [31:0] ed, input bit hold);
        exp_t e;
        bus.req_cmd_in  = cmd;
        bus.req_data_in = a;
        e.resp = er;
        e.data = ed;
        e.at   = cyc + 2 + LAT;
        sb.push_back(e);
        @(negedge c_clk);
        check("busy_op2", 32'(bus.busy), 32'h1);
        bus.req_cmd_in  = hold ? CMD_ADD : CMD_NOP;
        bus.req_data_in = b;
        @(negedge c_clk);
        bus.req_cmd_in  = hold ? CMD_ADD : CMD_NOP;
        bus.req_data_in = $urandom;
        wait_idle();
        bus.req_cmd_in  = CMD_NOP;
    endtask

    initial begin
        int k;
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1;
        bus.req_cmd_in  = CMD_NOP;
        bus.req_data_in = '0;
        repeat (3) @(negedge c_clk);
        check("rst_resp", 32'(bus.out_resp), 32'h0);
        check("rst_data", bus.out_data, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);

        // First command lands on the first edge after reset release.
        reset = 1'b0;
        issue(CMD_ADD, 32'h0000_0001, 32'h1FFF_FFFF, RESP_OK,  32'h2000_0000, 1'b0);
        issue(CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, RESP_ERR, 32'h0,         1'b0);
        issue(CMD_ADD, 32'h1FFF_FFFF, 32'h1FFF_FFFF, RESP_OK,  32'h3FFF_FFFE, 1'b0);
        issue(CMD_SUB, 32'h0000_0001, 32'h0000_000F, RESP_ERR, 32'h0,         1'b0);
        issue(CMD_SUB, 32'h0000_000F, 32'h0000_0001, RESP_OK,  32'h0000_000E, 1'b0);
        issue(CMD_SUB, 32'h1234_5678, 32'h1234_5678, RESP_OK,  32'h0,         1'b0);
        issue(CMD_SHL, 32'h0000_0001, 32'h0000_0021, RESP_OK,  32'h0000_0002, 1'b0);
        issue(CMD_SHR, 32'h8000_0000, 32'h0000_001F, RESP_OK,  32'h0000_0001, 1'b0);
        issue(CMD_SHL, 32'hF000_000F, 32'h0000_0004, RESP_OK,  32'h0000_00F0, 1'b0);
        issue(4'd3,    32'h0000_0005, 32'h0000_0006, RESP_ERR, 32'h0,         1'b0);
        issue(4'd4,    32'h0000_0005, 32'h0000_0006, RESP_ERR, 32'h0,         1'b0);
        issue(4'd15,   32'hFFFF_FFFF, 32'hFFFF_FFFF, RESP_ERR, 32'h0,         1'b0);
        issue(CMD_ADD, 32'h0000_0002, 32'h0000_0003, RESP_OK,  32'h0000_0005, 1'b1);

        // No-op command while idle must not start anything.
        bus.req_cmd_in  = CMD_NOP;
        bus.req_data_in = 32'hDEAD_BEEF;
        repeat (3) @(negedge c_clk);
        check("nop_busy", 32'(bus.busy), 32'h0);

        // Reset during EXEC aborts silently and swallows the command on the reset cycle.
        k = cyc + 1;
        bus.req_cmd_in  = CMD_ADD;
        bus.req_data_in = 32'h0000_0007;
        @(negedge c_clk);
        bus.req_cmd_in  = CMD_NOP;
        bus.req_data_in = 32'h0000_0008;
        @(negedge c_clk);
        reset = 1'b1;
        bus.req_cmd_in  = CMD_ADD;
        bus.req_data_in = 32'h0000_0009;
        @(negedge c_clk);
        reset = 1'b0;
        bus.req_cmd_in  = CMD_NOP;
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_resp", 32'(bus.out_resp), 32'h0);
        while (cyc < k + 10) @(negedge c_clk);
        issue(CMD_ADD, 32'h0, 32'h0, RESP_OK, 32'h0, 1'b0);

        repeat (10) @(negedge c_clk);
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
